// File: rtl/imem_load_ctrl.sv
// Shares the instruction memory between IF-stage word fetches (RUN) and a byte-stream boot loader (LOAD).
// Fetch data returns one cycle after the request. A DRAIN cycle lets the last loader write land before reads resume.
module imem_load_ctrl #(
    parameter int MEM_BYTES = 256,
    parameter int AW        = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_start,
    input  logic [8:0]  i_load_len,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    input  logic        i_fetch_req,
    input  logic [31:0] i_fetch_addr,
    output logic        o_fetch_valid,
    output logic [31:0] o_fetch_instr,
    output logic        o_fetch_err,
    output logic        o_stall,
    output logic        o_load_done,
    output logic [8:0]  o_bytes_loaded,
    output logic [31:0] o_mem_read_address,
    input  logic [31:0] i_mem_read_data,
    output logic [31:0] o_mem_write_address,
    output logic [7:0]  o_mem_write_data,
    output logic        o_mem_we
);

    localparam logic [31:0] LP_MEM_BYTES = 32'(MEM_BYTES);
    localparam logic [AW:0] LP_ONE       = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Counters are AW+1 bits so a full-memory load ends at MEM_BYTES instead of wrapping to 0.
    logic [AW:0] r_len;
    logic [AW:0] r_cnt;
    logic [AW:0] r_bytes;
    logic        r_fetch_valid;
    logic        r_fetch_err;
    logic        r_load_done;
    logic [31:0] r_rd_addr;

    logic        w_fetch_good;
    logic        w_start;
    logic        w_accept;
    logic        w_last;
    logic [AW:0] w_len_clamp;

    assign w_fetch_good = (i_fetch_addr[1:0] == 2'b00) && (i_fetch_addr < LP_MEM_BYTES);
    assign w_start      = (r_state == S_RUN) && i_load_start && (i_load_len != 9'd0);
    assign w_len_clamp  = (32'(i_load_len) > LP_MEM_BYTES) ? LP_MEM_BYTES[AW:0]
                                                           : (AW+1)'(i_load_len);
    assign w_accept     = (r_state == S_LOAD) && i_byte_valid;
    assign w_last       = ((r_cnt + LP_ONE) == r_len);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN:   if (w_start) w_next = S_LOAD;
            S_LOAD:  if (w_accept && w_last) w_next = S_DRAIN;
            S_DRAIN: w_next = S_RUN;
            default: w_next = S_RUN;
        endcase
    end

    always_comb begin
        o_stall            = 1'b0;
        o_byte_ready       = 1'b0;
        o_mem_we           = 1'b0;
        o_mem_write_data   = 8'h00;
        o_mem_read_address = i_fetch_addr;
        case (r_state)
            S_RUN: begin
                o_mem_read_address = i_fetch_addr;
            end
            S_LOAD: begin
                o_stall            = 1'b1;
                o_byte_ready       = 1'b1;
                o_mem_we           = i_byte_valid;
                o_mem_write_data   = i_byte_data;
                o_mem_read_address = r_rd_addr;
            end
            S_DRAIN: begin
                o_stall            = 1'b1;
                o_mem_read_address = r_rd_addr;
            end
            default: begin
                o_stall            = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len         <= '0;
            r_cnt         <= '0;
            r_bytes       <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_load_done   <= 1'b0;
            r_rd_addr     <= '0;
        end else begin
            r_fetch_valid <= (r_state == S_RUN) && i_fetch_req && w_fetch_good;
            r_fetch_err   <= (r_state == S_RUN) && i_fetch_req && !w_fetch_good;
            r_load_done   <= (r_state == S_DRAIN) ||
                             ((r_state == S_RUN) && i_load_start && (i_load_len == 9'd0));
            if (r_state == S_RUN) begin
                r_rd_addr <= i_fetch_addr;
            end
            if (w_start) begin
                r_len   <= w_len_clamp;
                r_cnt   <= '0;
                r_bytes <= '0;
            end else if (w_accept) begin
                r_cnt   <= r_cnt + LP_ONE;
                r_bytes <= r_bytes + LP_ONE;
            end
        end
    end

    assign o_fetch_valid       = r_fetch_valid;
    assign o_fetch_err         = r_fetch_err;
    assign o_fetch_instr       = r_fetch_valid ? i_mem_read_data : 32'h0;
    assign o_load_done         = r_load_done;
    assign o_bytes_loaded      = 9'(r_bytes);
    assign o_mem_write_address = 32'(r_cnt);

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: behavioural sync RAM, fetch vector table, scoreboarded fetch results,
// and hand-written load / reset sequences.
module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [8:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        stall;
    logic        load_done;
    logic [8:0]  bytes_loaded;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rd;
    logic [31:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        preload;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        exp_v;
        logic        exp_e;
        logic [31:0] exp_i;
    } vec_t;

    typedef struct {
        logic        v;
        logic        e;
        logic [31:0] instr;
    } exp_t;

    vec_t        vecs [9];
    exp_t        sbq [$];
    logic [7:0]  gmem [256];
    logic [7:0]  mem [256];
    logic [7:0]  lb [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    logic [7:0]  db [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0]  rb [3] = '{8'hAA, 8'hBB, 8'hCC};
    logic [7:0]  ra;

    imem_load_ctrl #(.MEM_BYTES(256), .AW(8)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_load_start        (load_start),
        .i_load_len          (load_len),
        .i_byte_valid        (byte_valid),
        .i_byte_data         (byte_data),
        .o_byte_ready        (byte_ready),
        .i_fetch_req         (fetch_req),
        .i_fetch_addr        (fetch_addr),
        .o_fetch_valid       (fetch_valid),
        .o_fetch_instr       (fetch_instr),
        .o_fetch_err         (fetch_err),
        .o_stall             (stall),
        .o_load_done         (load_done),
        .o_bytes_loaded      (bytes_loaded),
        .o_mem_read_address  (mem_raddr),
        .i_mem_read_data     (mem_rd),
        .o_mem_write_address (mem_waddr),
        .o_mem_write_data    (mem_wdata),
        .o_mem_we            (mem_we)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [31:0] pword(input int a);
        return {pat(a), pat(a + 1), pat(a + 2), pat(a + 3)};
    endfunction

    function automatic logic [31:0] gword(input int a);
        return {gmem[a], gmem[a + 1], gmem[a + 2], gmem[a + 3]};
    endfunction

    // Synchronous RAM: read-before-write on a same-edge collision falls out of the NBA ordering.
    assign ra = mem_raddr[7:0];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (mem_we) begin
            mem[mem_waddr[7:0]] <= mem_wdata;
        end
        mem_rd <= {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fcycle(input logic req, input logic [31:0] addr, input logic ev,
                          input logic ee, input logic [31:0] ei, input string tag);
        exp_t x;
        fetch_req  = req;
        fetch_addr = addr;
        x.v = ev; x.e = ee; x.instr = ei;
        sbq.push_back(x);
        tick();
        x = sbq.pop_front();
        chk({tag, ".valid"}, 32'(fetch_valid), 32'(x.v));
        chk({tag, ".err"},   32'(fetch_err),   32'(x.e));
        chk({tag, ".instr"}, fetch_instr,      x.instr);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) gmem[i] = pat(i);
        rst = 1'b1; preload = 1'b1; load_start = 1'b0; load_len = 9'd0;
        byte_valid = 1'b0; byte_data = 8'h00; fetch_req = 1'b1; fetch_addr = 32'h0;

        // Reset with a pending fetch
        tick(); tick();
        chk("rst.fetch_valid", 32'(fetch_valid), 0);
        chk("rst.fetch_err",   32'(fetch_err), 0);
        chk("rst.fetch_instr", fetch_instr, 0);
        chk("rst.load_done",   32'(load_done), 0);
        chk("rst.stall",       32'(stall), 0);
        chk("rst.byte_ready",  32'(byte_ready), 0);
        chk("rst.mem_we",      32'(mem_we), 0);
        chk("rst.bytes",       32'(bytes_loaded), 0);
        chk("rst.waddr",       mem_waddr, 0);
        chk("rst.wdata",       32'(mem_wdata), 0);
        chk("rst.raddr",       mem_raddr, 0);
        rst = 1'b0; preload = 1'b0; fetch_req = 1'b0;
        tick();
        chk("run.stall", 32'(stall), 0);
        chk("run.byte_ready", 32'(byte_ready), 0);

        // Fetch vectors against the preloaded pattern
        vecs[0] = '{1'b1, 32'd0,          1'b1, 1'b0, pword(0)};
        vecs[1] = '{1'b1, 32'd4,          1'b1, 1'b0, pword(4)};
        vecs[2] = '{1'b1, 32'd252,        1'b1, 1'b0, pword(252)};
        vecs[3] = '{1'b1, 32'd2,          1'b0, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 32'd256,        1'b0, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 32'h8000_0000,  1'b0, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 32'd8,          1'b0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'd255,        1'b0, 1'b1, 32'h0};
        vecs[8] = '{1'b1, 32'd128,        1'b1, 1'b0, pword(128)};
        for (int i = 0; i < 9; i++) begin
            fetch_addr = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d.raddr", i), mem_raddr, vecs[i].addr);
            fcycle(vecs[i].req, vecs[i].addr, vecs[i].exp_v, vecs[i].exp_e, vecs[i].exp_i,
                   $sformatf("vec%0d", i));
        end

        // 8-byte load with gaps; a fetch issued alongside load_start is still served
        load_start = 1'b1; load_len = 9'd8;
        fcycle(1'b1, 32'd0, 1'b1, 1'b0, gword(0), "start_fetch");
        load_start = 1'b0; fetch_req = 1'b0;
        chk("load.stall", 32'(stall), 1);
        chk("load.byte_ready", 32'(byte_ready), 1);
        for (int k = 0; k < 8; k++) begin
            byte_valid = 1'b0;
            #1;
            chk($sformatf("gap%0d.we", k), 32'(mem_we), 0);
            tick();
            byte_valid = 1'b1; byte_data = lb[k];
            #1;
            chk($sformatf("byte%0d.we", k), 32'(mem_we), 1);
            chk($sformatf("byte%0d.waddr", k), mem_waddr, 32'(k));
            chk($sformatf("byte%0d.wdata", k), 32'(mem_wdata), 32'(lb[k]));
            chk($sformatf("byte%0d.stall", k), 32'(stall), 1);
            gmem[k] = lb[k];
            tick();
        end
        byte_valid = 1'b0;
        #1;
        chk("drain.stall", 32'(stall), 1);
        chk("drain.byte_ready", 32'(byte_ready), 0);
        chk("drain.we", 32'(mem_we), 0);
        chk("drain.bytes", 32'(bytes_loaded), 8);
        chk("drain.load_done", 32'(load_done), 0);
        tick();
        chk("done.stall", 32'(stall), 0);
        chk("done.load_done", 32'(load_done), 1);
        fcycle(1'b1, 32'd0, 1'b1, 1'b0, 32'h20080005, "gap_word0");
        chk("done.pulse_once", 32'(load_done), 0);
        fcycle(1'b1, 32'd4, 1'b1, 1'b0, 32'h01095020, "gap_word4");
        chk("done.bytes", 32'(bytes_loaded), 8);

        // Fetch held high throughout a 4-byte load
        load_start = 1'b1; load_len = 9'd4;
        fcycle(1'b1, 32'd0, 1'b1, 1'b0, gword(0), "fl_start");
        load_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            byte_valid = 1'b1; byte_data = db[k]; gmem[k] = db[k];
            chk($sformatf("fl%0d.stall", k), 32'(stall), 1);
            fcycle(1'b1, 32'd0, 1'b0, 1'b0, 32'h0, $sformatf("fl%0d", k));
        end
        byte_valid = 1'b0;
        chk("fl_drain.stall", 32'(stall), 1);
        fcycle(1'b1, 32'd0, 1'b0, 1'b0, 32'h0, "fl_drain");
        chk("fl_run.stall", 32'(stall), 0);
        fcycle(1'b1, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF, "fl_first");
        fetch_req = 1'b0;

        // Zero-length load
        load_start = 1'b1; load_len = 9'd0;
        chk("len0.stall_pre", 32'(stall), 0);
        tick();
        load_start = 1'b0;
        chk("len0.load_done", 32'(load_done), 1);
        chk("len0.stall", 32'(stall), 0);
        tick();
        chk("len0.load_done_end", 32'(load_done), 0);
        chk("len0.stall_end", 32'(stall), 0);

        // Oversized length clamps to the full memory
        load_start = 1'b1; load_len = 9'd300;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 260; k++) begin
            byte_valid = 1'b1;
            byte_data  = (k < 256) ? 8'(k + 16) : 8'hEE;
            #1;
            chk($sformatf("max%0d.ready", k), 32'(byte_ready), (k < 256) ? 1 : 0);
            chk($sformatf("max%0d.we", k), 32'(mem_we), (k < 256) ? 1 : 0);
            if (k < 256) gmem[k] = byte_data;
            tick();
        end
        byte_valid = 1'b0;
        chk("max.bytes", 32'(bytes_loaded), 256);
        chk("max.stall", 32'(stall), 0);
        fcycle(1'b1, 32'd0,   1'b1, 1'b0, 32'h10111213, "max_word0");
        fcycle(1'b1, 32'd252, 1'b1, 1'b0, 32'h0C0D0E0F, "max_word252");
        fetch_req = 1'b0;

        // Reset after 3 of 8 bytes
        load_start = 1'b1; load_len = 9'd8;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            byte_valid = 1'b1; byte_data = rb[k]; gmem[k] = rb[k];
            tick();
        end
        byte_valid = 1'b0; rst = 1'b1;
        tick();
        chk("rstld.stall", 32'(stall), 0);
        chk("rstld.bytes", 32'(bytes_loaded), 0);
        chk("rstld.load_done", 32'(load_done), 0);
        chk("rstld.byte_ready", 32'(byte_ready), 0);
        rst = 1'b0;
        tick();
        chk("rstld.load_done2", 32'(load_done), 0);
        chk("rstld.stall2", 32'(stall), 0);
        fcycle(1'b1, 32'd0, 1'b1, 1'b0, 32'hAABBCC13, "rstld_word0");
        fetch_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Controller that owns the instruction memory's ports and shares them between the fetch stage and a byte-stream boot loader (e.g. UART receiver).
- In RUN it forwards word fetches to the memory's synchronous read port.
- In LOAD it writes an incoming byte stream into memory from address 0 upward, and stalls the pipeline until the image is complete.
- It sits between the IF stage and the instruction memory.

Parameters:
MEM_BYTES, 256, instruction memory size in bytes (power of two)
AW, 8, byte-address bits used inside the memory (log2 MEM_BYTES)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
load_start  in  1  single-cycle request to begin a load
load_len  in  9  bytes to load (0..256), sampled with load_start
byte_valid  in  1  loader byte available
byte_data  in  8  loader byte
byte_ready  out  1  controller accepts a byte this cycle
fetch_req  in  1  IF stage requests an instruction word
fetch_addr  in  32  byte address of the requested word
fetch_valid  out  1  fetch_instr valid this cycle
fetch_instr  out  32  fetched instruction, big-endian (lowest address = bits 31:24)
fetch_err  out  1  one-cycle pulse: misaligned or out-of-range fetch
stall  out  1  high while the memory is unavailable to fetch
load_done  out  1  one-cycle pulse when a load finishes
bytes_loaded  out  9  bytes written in the current or last load
mem_read_address  out  32  to memory read address
mem_read_data  in  32  from memory, registered one cycle after address
mem_write_address  out  32  to memory write address
mem_write_data  out  8  to memory write data
mem_we  out  1  memory write enable

Behaviour:
- States: RUN (reset state), LOAD, DRAIN.
- Reset values: state=RUN. All of the following are 0: fetch_valid, fetch_err, load_done, stall, byte_ready, mem_we, bytes_loaded, write counter, mem_write_address, mem_write_data, mem_read_address. fetch_instr=0.
- The memory samples read and write addresses on the rising clk edge. Read latency is one cycle. A read issued on the same edge as a write to the same byte returns the old data.

RUN:
- mem_read_address = fetch_addr (combinational).
- A request at edge k is "good" when fetch_req=1, fetch_addr[1:0]=0 and fetch_addr < MEM_BYTES. After edge k: fetch_valid=1 and fetch_instr=mem_read_data.
- If fetch_req=1 and the address is misaligned or >= MEM_BYTES: fetch_err=1 after edge k, fetch_valid=0.
- When fetch_valid=0, fetch_instr is driven to 0.
- load_start=1 with load_len=0: no state change; load_done pulses for one cycle after the edge.
- load_start=1 with load_len>0:
  - latch len = min(load_len, MEM_BYTES), write counter=0, bytes_loaded=0;
  - go to LOAD.
- A fetch presented in the same cycle as load_start is still served; its fetch_valid appears in the first LOAD cycle.

LOAD:
- stall=1 and byte_ready=1.
- mem_we = byte_valid (combinational). mem_write_address = counter, zero-extended. mem_write_data = byte_data.
- On each accepted byte: counter+1 and bytes_loaded+1.
- When the accepted byte is byte number len, go to DRAIN. byte_ready drops in DRAIN.
- fetch_req is ignored: no fetch_valid, no fetch_err.
- load_start is ignored.
- mem_read_address holds its last RUN value.
- Gaps in byte_valid are allowed with no timeout.

DRAIN:
- Lasts one cycle; stall=1, byte_ready=0, mem_we=0. This guarantees the last write has landed before any read.
- Then go to RUN, with load_done=1 for the first RUN cycle.

Boundaries and reset:
- len=256 fills addresses 0..255. The counter is AW+1 bits, so it cannot wrap onto address 0.
- rst mid-load: return to RUN on the next edge and clear counters. Bytes already written stay in memory. load_done does not pulse.
- rst has priority over every other input.

Test Plan:
- Reset: hold rst 2 cycles with fetch_req=1 -> all outputs 0; after release, state=RUN and stall=0.
- Load with gaps: load_start, load_len=8; drive bytes 8'h20,8'h08,8'h00,8'h05,8'h01,8'h09,8'h50,8'h20 with byte_valid low every other cycle -> 8 writes to addresses 0..7; stall high until the end of DRAIN; load_done pulses once; bytes_loaded=8. Then fetch 0 -> 32'h20080005 one cycle later; fetch 4 -> 32'h01095020.
- Fetch during load: fetch_req=1 throughout a 4-byte load -> no fetch_valid/fetch_err while stall=1; first fetch_valid appears one cycle after returning to RUN.
- Bad fetch addresses: fetch_addr=2 -> fetch_err pulse, fetch_valid=0; fetch_addr=256 -> fetch_err; fetch_addr=252 -> valid word.
- Degenerate and max lengths: load_len=0 -> load_done next cycle, stall never asserted. load_len=300 -> exactly 256 bytes accepted, byte_ready low afterward, address 0 not rewritten.
- Reset mid-load: assert rst after 3 of 8 bytes -> next cycle RUN, bytes_loaded=0, no load_done; fetch 0 returns the 3 new bytes plus the old byte 3.
